i2s_dac_tx: RTL and testbench

//  Output end of the audio path: takes filtered 24-bit stereo sample pairs through a write/write_ready

---
 rtl/i2s_dac_tx.sv | 167 ++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: buffers stereo sample pairs in a small FIFO and serializes them with generated BCLK/LRCK.
// Optional `HOLD_LAST_EN: underrun frames repeat the last popped pair instead of sending zeros.
module i2s_dac_tx #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int BCLK_DIV   = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata_left,
  input  logic [DATA_W-1:0] writedata_right,
  output logic              write_ready,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(BCLK_DIV);

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } slot_t;

  slot_t             state;
  logic [DW-1:0]     div_cnt;
  logic [5:0]        bit_cnt;
  logic [5:0]        next_bit;
  logic              started;
  logic              bclk_tick;
  logic              bclk_fall;
  logic              frame_start;
  logic              data_bit;
  logic              shift_en;

  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] left_sr;
  logic [DATA_W-1:0] right_sr;
`ifdef HOLD_LAST_EN
  logic [DATA_W-1:0] last_l;
  logic [DATA_W-1:0] last_r;
`endif

  always_comb begin
    bclk_tick = (div_cnt == DW'(BCLK_DIV - 1));
    bclk_fall = bclk_tick && AUD_BCLK;
    next_bit  = bit_cnt + 6'd1;
    // The first cycle after reset release is treated as a frame start, so the
    // frame that restarts on release is a real frame with its own pop/underrun.
    frame_start = !started || (bclk_fall && (next_bit == 6'd0));
    data_bit    = (next_bit[4:0] != 5'd0) && (next_bit[4:0] <= 5'(DATA_W));
    shift_en    = bclk_fall && data_bit;
    fifo_empty  = (count == '0);
    push        = write && write_ready;
    pop         = frame_start && !fifo_empty;
    count_next  = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      AUD_BCLK <= 1'b0;
    end else if (bclk_tick) begin
      div_cnt  <= '0;
      AUD_BCLK <= ~AUD_BCLK;
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_l[wr_ptr] <= writedata_left;
      mem_r[wr_ptr] <= writedata_right;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      write_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= count_next;
      write_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LEFT;
      bit_cnt     <= '0;
      started     <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
      underrun    <= 1'b0;
      left_sr     <= '0;
      right_sr    <= '0;
`ifdef HOLD_LAST_EN
      last_l      <= '0;
      last_r      <= '0;
`endif
    end else begin
      started  <= 1'b1;
      underrun <= frame_start && fifo_empty;

      if (frame_start) begin
        if (!fifo_empty) begin
          left_sr  <= mem_l[rd_ptr];
          right_sr <= mem_r[rd_ptr];
`ifdef HOLD_LAST_EN
          last_l   <= mem_l[rd_ptr];
          last_r   <= mem_r[rd_ptr];
`endif
        end else begin
`ifdef HOLD_LAST_EN
          left_sr  <= last_l;
          right_sr <= last_r;
`else
          left_sr  <= '0;
          right_sr <= '0;
`endif
        end
      end else if (shift_en) begin
        if (next_bit[5]) right_sr <= right_sr << 1;
        else             left_sr  <= left_sr << 1;
      end

      if (bclk_fall) begin
        bit_cnt <= next_bit;
        unique case (state)
          LEFT: if (bit_cnt == 6'd31) begin
            state       <= RIGHT;
            AUD_DACLRCK <= 1'b1;
          end
          RIGHT: if (bit_cnt == 6'd63) begin
            state       <= LEFT;
            AUD_DACLRCK <= 1'b0;
          end
          default: begin
            state       <= LEFT;
            AUD_DACLRCK <= 1'b0;
          end
        endcase
        // Slot bit 0 and the padding bits after the LSB are always zero.
        if (data_bit) AUD_DACDAT <= next_bit[5] ? right_sr[DATA_W-1] : left_sr[DATA_W-1];
        else          AUD_DACDAT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: write-table vectors, reset/underrun/full-FIFO sequences and an I2S frame monitor.
`timescale 1ns/1ps
module tb_i2s_dac_tx;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        write;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;
  logic        write_ready;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;
  logic        underrun;

  i2s_dac_tx #(.DATA_W(24), .FIFO_DEPTH(4), .BCLK_DIV(16)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset_n         (reset_n),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .write_ready     (write_ready),
    .AUD_BCLK        (AUD_BCLK),
    .AUD_DACLRCK     (AUD_DACLRCK),
    .AUD_DACDAT      (AUD_DACDAT),
    .underrun        (underrun)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected I2S frame word: {left slot bits 0..31, right slot bits 0..31}.
  function automatic logic [63:0] fw(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  // Monitor: samples on CLOCK_50 falling edges, decodes DAC bits at BCLK rises.
  logic [63:0] frames[$];
  logic [31:0] cap_l, cap_r;
  int ncyc = 0, slot_idx = 0, last_rise = -1, last_lrck_rise = -1, und_len = 0;
  int bclk_bad = 0, bclk_hi_bad = 0, lrck_bad = 0, lrck_hi_bad = 0, dac_bad = 0;
  int und_bad = 0, und_pulses = 0, bclk_rises = 0, lrck_rises = 0;
  logic bclk_prev = 1'b0, lrck_prev = 1'b0, dac_prev = 1'b0, lrck_at_rise = 1'b1;

  always @(negedge CLOCK_50) begin
    ncyc++;
    if (!reset_n) begin
      frames.delete();
      slot_idx = 0; last_rise = -1; last_lrck_rise = -1; und_len = 0;
      und_pulses = 0; und_bad = 0;
      bclk_prev = 1'b0; lrck_prev = 1'b0; dac_prev = 1'b0; lrck_at_rise = 1'b1;
      cap_l = '0; cap_r = '0;
    end else begin
      if (AUD_BCLK && !bclk_prev) begin
        bclk_rises++;
        if (AUD_DACDAT !== dac_prev) dac_bad++;
        if (last_rise >= 0 && ncyc - last_rise != 32) bclk_bad++;
        last_rise = ncyc;
        if (AUD_DACLRCK != lrck_at_rise) slot_idx = 0;
        else slot_idx++;
        if (slot_idx < 32) begin
          if (AUD_DACLRCK) cap_r[31-slot_idx] = AUD_DACDAT;
          else             cap_l[31-slot_idx] = AUD_DACDAT;
        end
        if (AUD_DACLRCK && slot_idx == 31) frames.push_back({cap_l, cap_r});
        lrck_at_rise = AUD_DACLRCK;
      end
      if (!AUD_BCLK && bclk_prev && last_rise >= 0 && ncyc - last_rise != 16) bclk_hi_bad++;
      if (AUD_DACLRCK && !lrck_prev) begin
        lrck_rises++;
        if (last_lrck_rise >= 0 && ncyc - last_lrck_rise != 2048) lrck_bad++;
        last_lrck_rise = ncyc;
      end
      if (!AUD_DACLRCK && lrck_prev && last_lrck_rise >= 0 && ncyc - last_lrck_rise != 1024) lrck_hi_bad++;
      if (underrun) und_len++;
      else if (und_len > 0) begin
        und_pulses++;
        if (und_len != 1) und_bad++;
        und_len = 0;
      end
      bclk_prev = AUD_BCLK;
      lrck_prev = AUD_DACLRCK;
      dac_prev  = AUD_DACDAT;
    end
  end

  task automatic do_write(input logic [23:0] l, input logic [23:0] r);
    @(negedge CLOCK_50);
    write = 1'b1; writedata_left = l; writedata_right = r;
    @(negedge CLOCK_50);
    write = 1'b0;
  endtask

  task automatic wait_underrun(input int limit, input string name);
    int n = 0;
    while (!underrun && n < limit) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(name, 64'(underrun), 64'd1);
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        exp_ready;
  } wvec_t;

  wvec_t       wtab[5];
  logic [63:0] exp_frames[9];

  initial begin
    #(50000 * 20);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    wtab[0] = '{24'd100, 24'hF00000 | 24'd100, 1'b1};
    wtab[1] = '{24'd200, 24'hF00000 | 24'd200, 1'b1};
    wtab[2] = '{24'd300, 24'hF00000 | 24'd300, 1'b1};
    wtab[3] = '{24'd400, 24'hF00000 | 24'd400, 1'b1};
    wtab[4] = '{24'd500, 24'hF00000 | 24'd500, 1'b0};

    exp_frames[0] = '0;
    exp_frames[1] = fw(24'hABCDEF, 24'h123456);
`ifdef HOLD_LAST_EN
    exp_frames[2] = fw(24'hABCDEF, 24'h123456);
    exp_frames[8] = fw(24'd600, 24'hF00000 | 24'd600);
`else
    exp_frames[2] = '0;
    exp_frames[8] = '0;
`endif
    for (int i = 0; i < 4; i++) exp_frames[3+i] = fw(wtab[i].l, wtab[i].r);
    exp_frames[7] = fw(24'd600, 24'hF00000 | 24'd600);

    reset_n = 1'b0; write = 1'b0; writedata_left = '0; writedata_right = '0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_bclk", 64'(AUD_BCLK), 64'd0);
    check("rst_lrck", 64'(AUD_DACLRCK), 64'd0);
    check("rst_ready", 64'(write_ready), 64'd1);
    reset_n = 1'b1;

    // Reset mid RIGHT slot with three pairs queued.
    do_write(24'h111111, 24'h222222);
    do_write(24'h333333, 24'h444444);
    do_write(24'h555555, 24'h666666);
    n = 0;
    while (!(AUD_DACLRCK && AUD_BCLK) && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("reach_right_slot", 64'(AUD_DACLRCK && AUD_BCLK), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_bclk", 64'(AUD_BCLK), 64'd0);
    check("midrst_lrck", 64'(AUD_DACLRCK), 64'd0);
    check("midrst_dacdat", 64'(AUD_DACDAT), 64'd0);
    check("midrst_underrun", 64'(underrun), 64'd0);
    check("midrst_ready", 64'(write_ready), 64'd1);
    repeat (4) @(negedge CLOCK_50);
    reset_n = 1'b1;

    // First frame after release: empty FIFO -> underrun, zero frame.
    wait_underrun(2200, "underrun_after_reset");
    do_write(24'hABCDEF, 24'h123456);
    // Frame after the ABCDEF frame finds the FIFO empty.
    wait_underrun(4300, "underrun_empty_fifo");

    // Back-to-back writes straight after a frame start; 5th must be dropped.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ready_before_wr%0d", i), 64'(write_ready), 64'(wtab[i].exp_ready));
      write = 1'b1; writedata_left = wtab[i].l; writedata_right = wtab[i].r;
      @(negedge CLOCK_50);
    end
    write = 1'b0;
    check("ready_full_after_drop", 64'(write_ready), 64'd0);
    check("underrun_single_cycle", 64'(und_bad), 64'd0);

    // Full FIFO: the next pop frees a slot, and a write on the following cycle is taken.
    n = 0;
    while (!write_ready && n < 2200) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("ready_after_pop", 64'(write_ready), 64'd1);
    write = 1'b1; writedata_left = 24'd600; writedata_right = 24'hF00000 | 24'd600;
    @(negedge CLOCK_50);
    write = 1'b0;
    check("ready_full_again", 64'(write_ready), 64'd0);

    n = 0;
    while (frames.size() < 9 && n < 20000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("frame_count", 64'(frames.size() >= 9), 64'd1);
    for (int i = 0; i < 9; i++)
      check($sformatf("frame%0d", i), (i < frames.size()) ? frames[i] : 64'hx, exp_frames[i]);

    check("underrun_pulses", 64'(und_pulses), 64'd3);
    check("underrun_width", 64'(und_bad), 64'd0);
    check("bclk_period", 64'(bclk_bad), 64'd0);
    check("bclk_duty", 64'(bclk_hi_bad), 64'd0);
    check("lrck_period", 64'(lrck_bad), 64'd0);
    check("lrck_duty", 64'(lrck_hi_bad), 64'd0);
    check("dacdat_stable_on_rise", 64'(dac_bad), 64'd0);
    check("clock_activity", 64'(bclk_rises > 500 && lrck_rises >= 5), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
